// File: rtl/result_text_pkg.sv
// Shared character codes, fixed line text and field positions for the result text ROM.
package result_text_pkg;

    localparam logic [6:0] CH_BLANK = 7'd0;
    localparam logic [6:0] CH_ZERO  = 7'd48;
    localparam logic [6:0] CH_COLON = 7'd58;

    // Text tables are right-aligned in 128 bits; column 1 holds the first character.
    localparam int TEXT_W = 128;
    localparam logic [TEXT_W-1:0] LINE0_TEXT       = {8'd0, "Congratulation!"};
    localparam logic [TEXT_W-1:0] SCORE_LABEL_TEXT = {40'd0, "Your score:"};
    localparam logic [TEXT_W-1:0] TIME_LABEL_TEXT  = {48'd0, "Your time:"};

    localparam int LINE0_ROW       = 0;
    localparam int LINE0_LEN       = 15;
    localparam int SCORE_ROW       = 2;
    localparam int SCORE_LABEL_LEN = 11;
    localparam int SCORE_END_BASE  = 12;  // last score digit sits at SCORE_END_BASE + SCORE_DIGITS
    localparam int TIME_ROW        = 4;
    localparam int TIME_LABEL_LEN  = 10;
    localparam int TIME_COL        = 12;  // MM:SS occupies TIME_COL .. TIME_COL+4

    typedef enum logic [0:0] {
        CONV_IDLE,
        CONV_SHIFT
    } conv_state_e;

    function automatic logic [6:0] text_at(input logic [TEXT_W-1:0] txt, input int len,
                                           input int col);
        logic [6:0] ch;
        ch = CH_BLANK;
        if (col >= 1 && col <= len) begin
            ch = txt[8*(len-col) +: 7];
        end
        return ch;
    endfunction

endpackage

// File: rtl/result_text_rom_bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per cycle.
// Values above 10^SCORE_DIGITS-1 saturate to all nines.
module bin2bcd_seq
    import result_text_pkg::*;
#(
    parameter int SCORE_W      = 14,
    parameter int SCORE_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [SCORE_W-1:0]        bin,
    output logic                      busy,
    output logic                      done,
    output logic [4*SCORE_DIGITS-1:0] bcd
);

    localparam int          BCD_W   = 4 * SCORE_DIGITS;
    localparam int          CNT_W   = $clog2(SCORE_W + 1);
    localparam logic [63:0] MAX_VAL = 64'(10 ** SCORE_DIGITS) - 64'd1;

    conv_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   bcd_adj;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        bcd_adj = bcd_q;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            CONV_IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(SCORE_W);
                    ovf_d   = 64'(bin) > MAX_VAL;
                    state_d = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = CONV_IDLE;
                end else begin
                    {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                    cnt_d          = cnt_q - 1'b1;
                end
            end
            default: state_d = CONV_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CONV_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != CONV_IDLE);
    assign done = (state_q == CONV_SHIFT) && (cnt_q == '0);
    assign bcd  = ovf_q ? {SCORE_DIGITS{4'h9}} : bcd_q;

endmodule

// File: rtl/result_text_rom.sv
// Result screen character ROM: fixed text plus snapshot score and MM:SS time.
// Optional score blinking is enabled by defining RESULT_TEXT_BLINK_EN.
module result_text_rom
    import result_text_pkg::*;
#(
    parameter int COLS         = 17,
    parameter int ROWS         = 5,
    parameter int SCORE_W      = 14,
    parameter int SCORE_DIGITS = 4,
    parameter int BLINK_FRAMES = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               latch,
    input  logic [SCORE_W-1:0] score,
    input  logic [6:0]         minutes_dozens_unity,
    input  logic [6:0]         seconds_dozens_unity,
    input  logic               frame_tick,
    input  logic [9:0]         char_yx,
    output logic [6:0]         char_code,
    output logic               busy
);

    localparam int BCD_W = 4 * SCORE_DIGITS;

    logic             conv_start, conv_busy, conv_done;
    logic [BCD_W-1:0] conv_bcd;

    logic [6:0]        pend_min_q, pend_min_d, pend_sec_q, pend_sec_d;
    logic [6:0]        shown_min_q, shown_min_d, shown_sec_q, shown_sec_d;
    logic [BCD_W-1:0]  shown_digits_q, shown_digits_d;
    logic [6:0]        char_code_q, char_code_d;
    logic [SCORE_DIGITS-1:0] digit_show;
    logic              blink_hidden;

    assign conv_start = latch & ~conv_busy;

    bin2bcd_seq #(
        .SCORE_W      (SCORE_W),
        .SCORE_DIGITS (SCORE_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (score),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Time is held pending during conversion so score and time switch over together.
    always_comb begin
        pend_min_d     = pend_min_q;
        pend_sec_d     = pend_sec_q;
        shown_min_d    = shown_min_q;
        shown_sec_d    = shown_sec_q;
        shown_digits_d = shown_digits_q;
        if (conv_start) begin
            pend_min_d = minutes_dozens_unity;
            pend_sec_d = seconds_dozens_unity;
        end
        if (conv_done) begin
            shown_digits_d = conv_bcd;
            shown_min_d    = pend_min_q;
            shown_sec_d    = pend_sec_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_min_q     <= '0;
            pend_sec_q     <= '0;
            shown_min_q    <= '0;
            shown_sec_q    <= '0;
            shown_digits_q <= '0;
            char_code_q    <= CH_BLANK;
        end else begin
            pend_min_q     <= pend_min_d;
            pend_sec_q     <= pend_sec_d;
            shown_min_q    <= shown_min_d;
            shown_sec_q    <= shown_sec_d;
            shown_digits_q <= shown_digits_d;
            char_code_q    <= char_code_d;
        end
    end

`ifdef RESULT_TEXT_BLINK_EN
    localparam int BLINK_CNT_W = $clog2(BLINK_FRAMES + 1);

    logic [BLINK_CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic                   blink_hidden_q, blink_hidden_d;

    always_comb begin
        blink_cnt_d    = blink_cnt_q;
        blink_hidden_d = blink_hidden_q;
        if (frame_tick) begin
            if (blink_cnt_q == BLINK_CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d    = '0;
                blink_hidden_d = ~blink_hidden_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q    <= '0;
            blink_hidden_q <= 1'b0;
        end else begin
            blink_cnt_q    <= blink_cnt_d;
            blink_hidden_q <= blink_hidden_d;
        end
    end

    assign blink_hidden = blink_hidden_q;
`else
    localparam int UNUSED_BLINK_FRAMES = BLINK_FRAMES;
    logic unused_frame_tick;
    assign unused_frame_tick = frame_tick;
    assign blink_hidden      = 1'b0;
`endif

    // Leading-zero blanking: a digit shows once any more significant digit is non-zero.
    always_comb begin
        logic seen;
        seen       = 1'b0;
        digit_show = '0;
        for (int k = SCORE_DIGITS - 1; k >= 0; k--) begin
            seen          = seen | (shown_digits_q[4*k +: 4] != 4'd0);
            digit_show[k] = seen | (k == 0);
        end
    end

    always_comb begin
        int y;
        int x;
        int k;
        y           = int'(char_yx[9:5]);
        x           = int'(char_yx[4:0]);
        k           = 0;
        char_code_d = CH_BLANK;
        if (y < ROWS && x < COLS) begin
            if (y == LINE0_ROW) begin
                char_code_d = text_at(LINE0_TEXT, LINE0_LEN, x);
            end else if (y == SCORE_ROW) begin
                if (x <= SCORE_LABEL_LEN) begin
                    char_code_d = text_at(SCORE_LABEL_TEXT, SCORE_LABEL_LEN, x);
                end else if (x > SCORE_END_BASE && x <= SCORE_END_BASE + SCORE_DIGITS) begin
                    k = SCORE_END_BASE + SCORE_DIGITS - x;
                    if (digit_show[k] && !blink_hidden) begin
                        char_code_d = CH_ZERO + {3'b000, shown_digits_q[4*k +: 4]};
                    end
                end
            end else if (y == TIME_ROW) begin
                if (x <= TIME_LABEL_LEN) begin
                    char_code_d = text_at(TIME_LABEL_TEXT, TIME_LABEL_LEN, x);
                end else begin
                    case (x - TIME_COL)
                        0:       char_code_d = CH_ZERO + {4'b0000, shown_min_q[6:4]};
                        1:       char_code_d = CH_ZERO + {3'b000, shown_min_q[3:0]};
                        2:       char_code_d = CH_COLON;
                        3:       char_code_d = CH_ZERO + {4'b0000, shown_sec_q[6:4]};
                        4:       char_code_d = CH_ZERO + {3'b000, shown_sec_q[3:0]};
                        default: char_code_d = CH_BLANK;
                    endcase
                end
            end
        end
    end

    assign char_code = char_code_q;
    assign busy      = conv_busy;

endmodule

// File: tb/tb_result_text_rom.sv
// Directed self-checking bench for result_text_rom (default parameters).
module tb_result_text_rom;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        latch = 1'b0;
    logic        frame_tick = 1'b0;
    logic [13:0] score = '0;
    logic [6:0]  minutes_dozens_unity = '0;
    logic [6:0]  seconds_dozens_unity = '0;
    logic [9:0]  char_yx = '0;
    logic [6:0]  char_code;
    logic        busy;

    int checks = 0;
    int failures = 0;

    result_text_rom dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .latch                (latch),
        .score                (score),
        .minutes_dozens_unity (minutes_dozens_unity),
        .seconds_dozens_unity (seconds_dozens_unity),
        .frame_tick           (frame_tick),
        .char_yx              (char_yx),
        .char_code            (char_code),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_char(input string tag, input int y, input int x, input int exp);
        @(negedge clk);
        char_yx = {5'(y), 5'(x)};
        @(negedge clk);
        check(tag, int'(char_code), exp);
    endtask

    task automatic check_score(input string tag, input int d3, input int d2, input int d1,
                               input int d0);
        check_char({tag, "_c13"}, 2, 13, d3);
        check_char({tag, "_c14"}, 2, 14, d2);
        check_char({tag, "_c15"}, 2, 15, d1);
        check_char({tag, "_c16"}, 2, 16, d0);
    endtask

    task automatic do_latch(input int s, input logic [6:0] m, input logic [6:0] sec);
        @(negedge clk);
        score                = 14'(s);
        minutes_dozens_unity = m;
        seconds_dozens_unity = sec;
        latch                = 1'b1;
        @(negedge clk);
        latch = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_frames(input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    initial begin
        int n;
        #1;
        check("reset_char_code", int'(char_code), 0);
        check("reset_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Fixed text, blanking and the reset snapshot
        check_char("line0_c1_C", 0, 1, 67);
        check_char("line0_c0_blank", 0, 0, 0);
        check_char("line0_c15_bang", 0, 15, 33);
        check_char("line2_c1_Y", 2, 1, 89);
        check_char("line2_c11_colon", 2, 11, 58);
        check_char("line4_c10_colon", 4, 10, 58);
        check_char("line1_blank", 1, 5, 0);
        check_char("row_out_of_range", 5, 1, 0);
        check_char("col_out_of_range", 4, 20, 0);
        check_score("reset_score", 0, 0, 0, 48);
        check_char("reset_time_c12", 4, 12, 48);
        check_char("reset_time_c14", 4, 14, 58);
        check_char("reset_time_c16", 4, 16, 48);

        // 1234: busy for exactly 15 cycles, then four digits
        do_latch(1234, 7'h01, 7'h02);
        wait_idle(n);
        check("busy_len_1234", n, 15);
        check_score("score_1234", 49, 50, 51, 52);

        // 7 then an ignored 9999 five cycles later; old digits held while busy
        do_latch(7, 7'h03, 7'h04);
        check_char("shadow_c16", 2, 16, 52);
        check_char("shadow_c13", 2, 13, 49);
        score = 14'd9999;
        latch = 1'b1;
        @(negedge clk);
        latch = 1'b0;
        wait_idle(n);
        check("busy_remaining_after_ignored", n, 10);
        repeat (3) @(negedge clk);
        check("no_restart_busy", int'(busy), 0);
        check_score("score_7", 0, 0, 0, 55);
        check_char("time_after_7_c13", 4, 13, 51);

        // Saturation and time field
        do_latch(12000, 7'h25, 7'h07);
        wait_idle(n);
        check("busy_len_12000", n, 15);
        check_score("score_sat", 57, 57, 57, 57);
        check_char("time_c12", 4, 12, 50);
        check_char("time_c13", 4, 13, 53);
        check_char("time_c14", 4, 14, 58);
        check_char("time_c15", 4, 15, 48);
        check_char("time_c16", 4, 16, 55);

        // Reset mid-conversion aborts and clears the snapshot
        do_latch(4321, 7'h11, 7'h22);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_char_code", int'(char_code), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_score("after_abort", 0, 0, 0, 48);
        check_char("after_abort_time", 4, 12, 48);
        do_latch(56, 7'h12, 7'h34);
        wait_idle(n);
        check("busy_len_56", n, 15);
        check_score("score_56", 0, 0, 53, 54);
        check_char("time_56_c16", 4, 16, 52);

`ifdef RESULT_TEXT_BLINK_EN
        pulse_frames(31);
        check_char("blink_31_visible", 2, 16, 54);
        pulse_frames(1);
        check_char("blink_hidden_c16", 2, 16, 0);
        check_char("blink_hidden_c15", 2, 15, 0);
        check_char("blink_hidden_time", 4, 16, 52);
        check_char("blink_hidden_label", 2, 1, 89);
        pulse_frames(32);
        check_char("blink_restored_c16", 2, 16, 54);
        check_char("blink_restored_c15", 2, 15, 53);
        check_char("blink_restored_time", 4, 16, 52);
`else
        pulse_frames(40);
        check_char("no_blink_c16", 2, 16, 54);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
